race_lights_controller: RTL and testbench



---
 rtl/race_lights_controller.sv | 83 ++++++++
 tb/tb_race_lights_controller.sv | 134 +++++++++++++
 2 files changed

// File: rtl/race_lights_controller.sv
// Race start tree sequencer: Red, then Yellow, then Green held until reset.
// Lamp outputs are registered from the next state, so they track the state with no extra lag.
module race_lights_controller #(
    parameter int unsigned RED_CYCLES    = 3,
    parameter int unsigned YELLOW_CYCLES = 3
) (
    input  logic Clk,
    input  logic nReset,
    input  logic Start,
    output logic R,
    output logic Y,
    output logic G
);

    // A count of 0 is treated as 1.
    localparam int unsigned RedEff    = (RED_CYCLES == 0) ? 1 : RED_CYCLES;
    localparam int unsigned YellowEff = (YELLOW_CYCLES == 0) ? 1 : YELLOW_CYCLES;
    localparam logic [15:0] red_last    = 16'(RedEff - 1);
    localparam logic [15:0] yellow_last = 16'(YellowEff - 1);

    typedef enum logic [1:0] {
        st_idle   = 2'd0,
        st_red    = 2'd1,
        st_yellow = 2'd2,
        st_green  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            st_idle: begin
                if (Start) begin
                    state_d = st_red;
                    cnt_d   = '0;
                end
            end
            st_red: begin
                if (cnt_q == red_last) begin
                    state_d = st_yellow;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            st_yellow: begin
                if (cnt_q == yellow_last) begin
                    state_d = st_green;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            st_green: begin
                state_d = st_green;
            end
            default: begin
                state_d = st_idle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (nReset) begin
            state_q <= st_idle;
            cnt_q   <= '0;
            R       <= 1'b0;
            Y       <= 1'b0;
            G       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            R       <= (state_d == st_red);
            Y       <= (state_d == st_yellow);
            G       <= (state_d == st_green);
        end
    end

endmodule

// File: tb/tb_race_lights_controller.sv
// Directed bench for race_lights_controller: default timing DUT plus a RED=1/YELLOW=5 DUT,
// expected lamp patterns queued at drive time and checked after each edge.
module tb_race_lights_controller;

    logic Clk;
    logic nReset;
    logic Start;
    logic ra, ya, ga;
    logic rb, yb, gb;

    int tests = 0;
    int fails = 0;

    logic [2:0] qa[$];
    logic [2:0] qb[$];

    race_lights_controller #(
        .RED_CYCLES    (3),
        .YELLOW_CYCLES (3)
    ) dut_a (
        .Clk    (Clk),
        .nReset (nReset),
        .Start  (Start),
        .R      (ra),
        .Y      (ya),
        .G      (ga)
    );

    race_lights_controller #(
        .RED_CYCLES    (1),
        .YELLOW_CYCLES (5)
    ) dut_b (
        .Clk    (Clk),
        .nReset (nReset),
        .Start  (Start),
        .R      (rb),
        .Y      (yb),
        .G      (gb)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Lamps {R,Y,G} expected n edges after the starting edge (n = 0 is the starting edge).
    function automatic logic [2:0] seq_lamps(input int n, input int red, input int yel);
        if (n < red)            return 3'b100;
        else if (n < red + yel) return 3'b010;
        else                    return 3'b001;
    endfunction

    task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed RYG=%b expected RYG=%b", tag, obs, exp);
        end
    endtask

    task automatic check_onehot(input string tag, input logic [2:0] obs);
        logic ok;
        ok = ($countones(obs) <= 1) && !$isunknown(obs);
        tests++;
        assert (ok === 1'b1) else begin
            fails++;
            $error("FAIL %s: observed RYG=%b expected at most one lamp lit", tag, obs);
        end
    endtask

    // Drive one cycle of stimulus, queue expectations, then compare after the edge.
    task automatic cyc(input string tag, input logic rst, input logic st,
                       input logic [2:0] ea, input logic [2:0] eb);
        logic [2:0] xa, xb;
        nReset = rst;
        Start  = st;
        qa.push_back(ea);
        qb.push_back(eb);
        @(posedge Clk);
        #1;
        if (qa.size() == 0 || qb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            xa = qa.pop_front();
            xb = qb.pop_front();
            check3({tag, "_a"}, {ra, ya, ga}, xa);
            check3({tag, "_b"}, {rb, yb, gb}, xb);
            check_onehot({tag, "_a_1hot"}, {ra, ya, ga});
            check_onehot({tag, "_b_1hot"}, {rb, yb, gb});
        end
    endtask

    initial begin
        nReset = 1'b1;
        Start  = 1'b1;
        @(negedge Clk);

        // Reset wins over Start.
        cyc("reset0", 1'b1, 1'b1, 3'b000, 3'b000);
        cyc("reset1", 1'b1, 1'b1, 3'b000, 3'b000);

        // Start pulsed for one cycle, then held in Green for 24 cycles.
        for (int n = 0; n < 30; n++)
            cyc("pulse", 1'b0, (n == 0), seq_lamps(n, 3, 3), seq_lamps(n, 1, 5));

        // Start held high throughout: same timing, Green never restarts.
        cyc("reset2", 1'b1, 1'b0, 3'b000, 3'b000);
        for (int n = 0; n < 30; n++)
            cyc("held", 1'b0, 1'b1, seq_lamps(n, 3, 3), seq_lamps(n, 1, 5));

        // Reset at edge k+4 (Yellow on the default DUT), then a fresh run.
        cyc("reset3", 1'b1, 1'b0, 3'b000, 3'b000);
        for (int n = 0; n < 4; n++)
            cyc("mid", 1'b0, (n == 0), seq_lamps(n, 3, 3), seq_lamps(n, 1, 5));
        cyc("midrst", 1'b1, 1'b0, 3'b000, 3'b000);
        for (int n = 0; n < 10; n++)
            cyc("restart", 1'b0, 1'b1, seq_lamps(n, 3, 3), seq_lamps(n, 1, 5));

        // Idle hold with Start low.
        cyc("reset4", 1'b1, 1'b0, 3'b000, 3'b000);
        for (int n = 0; n < 50; n++)
            cyc("idle", 1'b0, 1'b0, 3'b000, 3'b000);

        // Start after a long idle still launches the sequence.
        for (int n = 0; n < 8; n++)
            cyc("late", 1'b0, (n == 0), seq_lamps(n, 3, 3), seq_lamps(n, 1, 5));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
